m_mad_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one m_multiply_adder (y = 3*b + c, 2-cycle registered pipeline) among N_REQ requesters.
- Each requester offers operands with valid/ready. The block grants one requester per cycle and drives its operands into the datapath.
- A valid/id tag travels alongside the data so each result returns labelled with its requester id.
- Sits between the requester front-ends and the shared multiply-adder.

---
 rtl/m_mad_arbiter_pkg.sv | 15 +
 rtl/m_mad_arbiter_rr_pick.sv | 33 +++
 rtl/m_multiply_adder.sv | 30 +++
 rtl/m_mad_arbiter.sv | 91 +++++++++
 tb/tb_m_mad_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/m_mad_arbiter_pkg.sv
// Shared constants and tag type for the multiply-adder arbiter slice.
package m_mad_arbiter_pkg;

    localparam int B_W         = 16;
    localparam int C_W         = 32;
    localparam int Y_W         = 32;
    localparam int MAD_LATENCY = 2;
    localparam int TAG_ID_W    = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/m_mad_arbiter_rr_pick.sv
// Rotate-priority selector: first valid at or after the pointer wins.
module m_rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] w_valid,
    input  logic [ID_W-1:0]  w_ptr,
    output logic [N_REQ-1:0] w_grant,
    output logic [ID_W-1:0]  w_id,
    output logic             w_any
);

    logic [ID_W-1:0] idx;

    // Scan from farthest to nearest so the nearest valid overwrites last.
    always_comb begin
        w_grant = '0;
        w_id    = '0;
        w_any   = 1'b0;
        idx     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(w_ptr) + k) % N_REQ);
            if (w_valid[idx]) begin
                w_any = 1'b1;
                w_id  = idx;
            end
        end
        if (w_any) begin
            w_grant[w_id] = 1'b1;
        end
    end

endmodule

// File: rtl/m_multiply_adder.sv
// Two-stage datapath: registers b/c, then registers y = 3*b + c.
module m_multiply_adder
    import m_mad_arbiter_pkg::*;
(
    input  logic           w_clock,
    input  logic [B_W-1:0] w_b,
    input  logic [C_W-1:0] w_c,
    output logic [Y_W-1:0] r_y
);

    logic [B_W-1:0] b_q;
    logic [C_W-1:0] c_q;
    logic [Y_W-1:0] y_q;
    logic [Y_W-1:0] y_d;
    logic [Y_W-1:0] b_ext;

    always_comb begin
        b_ext = Y_W'(b_q);
        y_d   = (b_ext << 1) + b_ext + Y_W'(c_q);
    end

    always_ff @(posedge w_clock) begin
        b_q <= w_b;
        c_q <= w_c;
        y_q <= y_d;
    end

    assign r_y = y_q;

endmodule

// File: rtl/m_mad_arbiter.sv
// Round-robin sharing of one multiply-adder among N_REQ requesters,
// with an id tag pipeline that tracks the datapath stages.
module m_mad_arbiter
    import m_mad_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 w_clock,
    input  logic                 w_reset,
    input  logic                 w_enable,
    input  logic [N_REQ-1:0]     w_req_valid,
    input  logic [N_REQ*B_W-1:0] w_req_b,
    input  logic [N_REQ*C_W-1:0] w_req_c,
    output logic [N_REQ-1:0]     w_req_ready,
    output logic                 r_rsp_valid,
    output logic [ID_W-1:0]      r_rsp_id,
    output logic [Y_W-1:0]       w_rsp_y,
    output logic [1:0]           r_inflight
);

    logic [ID_W-1:0]  ptr_q, ptr_d;
    tag_t             s1_q, s1_d;
    tag_t             s2_q, s2_d;
    logic [1:0]       inflight_q, inflight_d;

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  pick_id;
    logic             pick_any;
    logic             accept;
    logic [B_W-1:0]   dp_b;
    logic [C_W-1:0]   dp_c;

    m_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .w_valid (w_req_valid),
        .w_ptr   (ptr_q),
        .w_grant (grant),
        .w_id    (pick_id),
        .w_any   (pick_any)
    );

    always_comb begin
        w_req_ready = '0;
        accept      = 1'b0;
        dp_b        = '0;
        dp_c        = '0;
        if (w_enable && !w_reset && pick_any) begin
            w_req_ready = grant;
            accept      = 1'b1;
            dp_b        = w_req_b[B_W*pick_id +: B_W];
            dp_c        = w_req_c[C_W*pick_id +: C_W];
        end
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = ID_W'((int'(pick_id) + 1) % N_REQ);
        end
        s1_d.valid = accept;
        s1_d.id    = accept ? TAG_ID_W'(pick_id) : '0;
        s2_d       = s1_q;
        inflight_d = {1'b0, s1_d.valid} + {1'b0, s2_d.valid};
    end

    always_ff @(posedge w_clock or posedge w_reset) begin
        if (w_reset) begin
            ptr_q      <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            inflight_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            inflight_q <= inflight_d;
        end
    end

    m_multiply_adder u_mad (
        .w_clock (w_clock),
        .w_b     (dp_b),
        .w_c     (dp_c),
        .r_y     (w_rsp_y)
    );

    assign r_rsp_valid = s2_q.valid;
    assign r_rsp_id    = ID_W'(s2_q.id);
    assign r_inflight  = inflight_q;

endmodule

// File: tb/tb_m_mad_arbiter.sv
// Bench for m_mad_arbiter: directed scenarios plus random traffic.
module tb_m_mad_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b0;
    logic [N-1:0]    valid = '0;
    logic [N*16-1:0] bv = '0;
    logic [N*32-1:0] cv = '0;
    logic [N-1:0]    ready;
    logic            rsp_valid;
    logic [IW-1:0]   rsp_id;
    logic [31:0]     rsp_y;
    logic [1:0]      inflight;

    m_mad_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
        .w_clock     (clk),
        .w_reset     (rst),
        .w_enable    (en),
        .w_req_valid (valid),
        .w_req_b     (bv),
        .w_req_c     (cv),
        .w_req_ready (ready),
        .r_rsp_valid (rsp_valid),
        .r_rsp_id    (rsp_id),
        .w_rsp_y     (rsp_y),
        .r_inflight  (inflight)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Reference model: pointer, two-deep result pipe, requester state.
    int          m_ptr = 0;
    logic        pv[2];
    int          pid[2];
    logic [31:0] py[2];
    logic [15:0] ob[N];
    logic [31:0] oc[N];
    logic [N-1:0] ov = '0;

    int          got_id[$];
    logic [31:0] got_y[$];
    int          got_cyc[$];
    int          gnt_seq[$];

    logic [N-1:0] ro, re;
    logic [36:0]  to, te;

    function automatic int pick(input logic [N-1:0] v, input int p,
                                input logic e);
        int best = -1;
        int bd = N;
        if (!e) return -1;
        for (int i = 0; i < N; i++) begin
            if (v[i] && ((i - p + N) % N) < bd) begin
                bd = (i - p + N) % N;
                best = i;
            end
        end
        return best;
    endfunction

    function automatic logic [36:0] rsp_tuple(input logic v,
        input logic [IW-1:0] id, input logic [31:0] y, input logic [1:0] inf);
        return {v, v ? id : 2'd0, v ? y : 32'd0, inf};
    endfunction

    task automatic reset_model();
        pv[0] = 1'b0; pv[1] = 1'b0;
        pid[0] = 0; pid[1] = 0;
        py[0] = '0; py[1] = '0;
        m_ptr = 0;
    endtask

    task automatic clear_log();
        got_id.delete(); got_y.delete(); got_cyc.delete(); gnt_seq.delete();
    endtask

    // One clock: drive ov/ob/oc, observe ready, advance model, observe result.
    task automatic step(output logic [N-1:0] r_o, output logic [N-1:0] r_e,
                        output logic [36:0] t_o, output logic [36:0] t_e);
        int g;
        valid = ov;
        for (int i = 0; i < N; i++) begin
            bv[16*i +: 16] = ob[i];
            cv[32*i +: 32] = oc[i];
        end
        #1;
        g = rst ? -1 : pick(ov, m_ptr, en);
        r_o = ready;
        r_e = '0;
        if (g >= 0) begin
            r_e[g] = 1'b1;
            gnt_seq.push_back(g);
        end
        @(posedge clk);
        cyc++;
        pv[1] = pv[0]; pid[1] = pid[0]; py[1] = py[0];
        pv[0] = (g >= 0);
        pid[0] = 0;
        py[0] = '0;
        if (g >= 0) begin
            pid[0] = g;
            py[0] = 32'(3 * longint'(ob[g]) + longint'(oc[g]));
            m_ptr = (g + 1) % N;
            ov[g] = 1'b0;
        end
        #1;
        if (rsp_valid === 1'b1) begin
            got_id.push_back(int'(rsp_id));
            got_y.push_back(rsp_y);
            got_cyc.push_back(cyc);
        end
        t_o = rsp_tuple(rsp_valid, rsp_id, rsp_y, inflight);
        t_e = rsp_tuple(pv[1], 2'(pid[1]), py[1],
                        2'(int'(pv[0]) + int'(pv[1])));
    endtask

    task automatic test_reset();
        en = 1'b1;
        valid = '1;
        #1;
        n_chk++;
        if ({ready, rsp_valid, rsp_id, inflight} !== '0) begin
            n_fail++;
            $display("FAIL reset_state got %b/%b/%0d/%0d want 0/0/0/0",
                     ready, rsp_valid, rsp_id, inflight);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        ov = '0;
        reset_model();
    endtask

    task automatic test_single();
        logic [1:0] infs[3];
        int c0 = cyc;
        clear_log();
        ob[0] = 16'd1; oc[0] = 32'd2; ov = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            step(ro, re, to, te);
            if (k < 3) infs[k] = inflight;
            n_chk++;
            if (ro !== re) begin n_fail++; $display("FAIL single_ready got %b want %b", ro, re); end
            n_chk++;
            if (to !== te) begin n_fail++; $display("FAIL single_rsp got %h want %h", to, te); end
        end
        n_chk++;
        if (got_y.size() != 1 || got_y[0] !== 32'd5 || got_id[0] != 0
            || got_cyc[0] != c0 + 2) begin
            n_fail++;
            $display("FAIL single_result got n=%0d want one result y=5 id=0 at cycle %0d",
                     got_y.size(), c0 + 2);
        end
        n_chk++;
        if ({infs[0], infs[1], infs[2]} !== {2'd1, 2'd1, 2'd0}) begin
            n_fail++;
            $display("FAIL single_inflight got %0d,%0d,%0d want 1,1,0",
                     infs[0], infs[1], infs[2]);
        end
    endtask

    task automatic test_stream();
        int c0 = cyc;
        clear_log();
        for (int k = 0; k < 5; k++) begin
            if (k < 3) begin
                ov[1] = 1'b1;
                ob[1] = 16'(3 + 2 * k);
                oc[1] = 32'(4 + 2 * k);
            end
            step(ro, re, to, te);
            n_chk++;
            if (ro !== re) begin n_fail++; $display("FAIL stream_ready got %b want %b", ro, re); end
            n_chk++;
            if (to !== te) begin n_fail++; $display("FAIL stream_rsp got %h want %h", to, te); end
        end
        n_chk++;
        if (got_y.size() != 3 || got_y[0] !== 32'd13 || got_y[1] !== 32'd21
            || got_y[2] !== 32'd29 || got_id[0] != 1 || got_id[2] != 1
            || got_cyc[0] != c0 + 2 || got_cyc[2] != c0 + 4) begin
            n_fail++;
            $display("FAIL stream_results got n=%0d want 13,21,29 id 1 back-to-back",
                     got_y.size());
        end
    endtask

    task automatic test_contention();
        int exp_g[5] = '{0, 1, 2, 3, 0};
        int bad = 0;
        rst = 1'b1;
        ov = '0;
        reset_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_log();
        for (int k = 0; k < 7; k++) begin
            for (int i = 0; i < N; i++) begin
                if (k < 5 && !ov[i]) begin
                    ov[i] = 1'b1;
                    ob[i] = 16'($urandom);
                    oc[i] = $urandom;
                end
            end
            if (k >= 5) ov = '0;
            step(ro, re, to, te);
            n_chk++;
            if (ro !== re) begin n_fail++; $display("FAIL contend_ready got %b want %b", ro, re); end
            n_chk++;
            if (to !== te) begin n_fail++; $display("FAIL contend_rsp got %h want %h", to, te); end
        end
        if (gnt_seq.size() != 5 || got_id.size() != 5) bad = 1;
        else for (int k = 0; k < 5; k++)
            if (gnt_seq[k] != exp_g[k] || got_id[k] != exp_g[k]) bad = 1;
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL contend_order got %0d grants %0d results want 0,1,2,3,0",
                     gnt_seq.size(), got_id.size());
        end
    endtask

    task automatic test_fairness();
        clear_log();
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                ov = 4'b0100; ob[2] = 16'd11; oc[2] = 32'd1;
            end
            if (k == 1) begin
                ov = 4'b1001;
                ob[0] = 16'd2; oc[0] = 32'd0;
                ob[3] = 16'd4; oc[3] = 32'd5;
            end
            step(ro, re, to, te);
            n_chk++;
            if (ro !== re) begin n_fail++; $display("FAIL fair_ready got %b want %b", ro, re); end
            n_chk++;
            if (to !== te) begin n_fail++; $display("FAIL fair_rsp got %h want %h", to, te); end
        end
        n_chk++;
        if (gnt_seq.size() != 3 || gnt_seq[0] != 2 || gnt_seq[1] != 3
            || gnt_seq[2] != 0) begin
            n_fail++;
            $display("FAIL fair_order got %0d grants want 2,3,0", gnt_seq.size());
        end
    endtask

    task automatic test_wrap();
        clear_log();
        ov[2] = 1'b1; ob[2] = 16'hFFFF; oc[2] = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            step(ro, re, to, te);
            n_chk++;
            if (to !== te) begin n_fail++; $display("FAIL wrap_rsp got %h want %h", to, te); end
        end
        n_chk++;
        if (got_y.size() != 1 || got_y[0] !== 32'd196604) begin
            n_fail++;
            $display("FAIL wrap_y got n=%0d want y=196604", got_y.size());
        end
    endtask

    task automatic test_enable();
        clear_log();
        en = 1'b0;
        ov[0] = 1'b1; ob[0] = 16'd7; oc[0] = 32'd9;
        for (int k = 0; k < 6; k++) begin
            if (k == 3) en = 1'b1;
            step(ro, re, to, te);
            n_chk++;
            if (ro !== re) begin n_fail++; $display("FAIL enable_ready got %b want %b", ro, re); end
            n_chk++;
            if (to !== te) begin n_fail++; $display("FAIL enable_rsp got %h want %h", to, te); end
        end
        n_chk++;
        if (got_y.size() != 1 || got_y[0] !== 32'd30 || got_cyc[0] != cyc - 1) begin
            n_fail++;
            $display("FAIL enable_result got n=%0d want single y=30 after re-enable",
                     got_y.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] y0;
        clear_log();
        ov[3] = 1'b1; ob[3] = 16'd10; oc[3] = 32'd1;
        step(ro, re, to, te);
        rst = 1'b1;
        valid = '1;
        #1;
        n_chk++;
        if ({ready, rsp_valid, inflight} !== '0) begin
            n_fail++;
            $display("FAIL midreset_state got %b/%b/%0d want 0/0/0",
                     ready, rsp_valid, inflight);
        end
        reset_model();
        @(posedge clk);
        #1;
        n_chk++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_drop got rsp_valid=%b want 0", rsp_valid);
        end
        rst = 1'b0;
        ov = '1;
        for (int i = 0; i < N; i++) begin
            ob[i] = 16'($urandom);
            oc[i] = $urandom;
        end
        y0 = 32'(3 * longint'(ob[0]) + longint'(oc[0]));
        for (int k = 0; k < 3; k++) begin
            step(ro, re, to, te);
            if (k == 0) begin
                n_chk++;
                if (ro !== 4'b0001) begin
                    n_fail++;
                    $display("FAIL midreset_ptr got %b want 0001", ro);
                end
                ov = '0;
            end
            n_chk++;
            if (to !== te) begin n_fail++; $display("FAIL midreset_rsp got %h want %h", to, te); end
        end
        n_chk++;
        if (got_y.size() != 1 || got_y[0] !== y0 || got_id[0] != 0) begin
            n_fail++;
            $display("FAIL midreset_after got n=%0d want one result id=0 y=%h",
                     got_y.size(), y0);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            en = ($urandom % 5) != 0;
            for (int i = 0; i < N; i++) begin
                if (k < 398 && !ov[i] && ($urandom % 2) == 0) begin
                    ov[i] = 1'b1;
                    ob[i] = ($urandom % 8 == 0) ? 16'hFFFF : 16'($urandom);
                    oc[i] = ($urandom % 8 == 0) ? 32'hFFFF_FFFF : $urandom;
                end
            end
            if (k >= 398) ov = '0;
            step(ro, re, to, te);
            n_chk++;
            if (ro !== re) begin n_fail++; $display("FAIL rand_ready cyc %0d got %b want %b", cyc, ro, re); end
            n_chk++;
            if (to !== te) begin n_fail++; $display("FAIL rand_rsp cyc %0d got %h want %h", cyc, to, te); end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            ob[i] = '0;
            oc[i] = '0;
        end
        reset_model();
        test_reset();
        test_single();
        test_stream();
        test_contention();
        test_fairness();
        test_wrap();
        test_enable();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
